// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the ticket-sale countdown timer.
// State encoding, LED patterns and the packed-BCD zero value.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LED_OFF   = 8'hFF;
  localparam logic [7:0] LED_FIRST = 8'hFE;
  localparam logic [7:0] LED_ON    = 8'h00;
  localparam logic [7:0] BCD_ZERO  = 8'h00;

endpackage

// File: rtl/countdown_timer_bcd_dec2.sv
// Combinational 2-digit packed-BCD decrementer with a digit-validity flag.
// 00 wraps to 99; o_valid is high when both nibbles are 0..9.
module bcd_dec2 (
  input  logic [7:0] i_bcd,
  output logic [7:0] o_dec,
  output logic       o_valid
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens  = i_bcd[7:4];
  assign w_ones  = i_bcd[3:0];
  assign o_valid = (w_tens <= 4'd9) && (w_ones <= 4'd9);

  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    o_dec = i_bcd;
    if (w_ones == 4'd0) begin
      o_dec[3:0] = 4'd9;
      o_dec[7:4] = (w_tens == 4'd0) ? 4'd9 : w_tens - 4'd1;
    end else begin
      o_dec[3:0] = w_ones - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Ticket-sale countdown clocked by the 1 Hz divided clock: BCD seconds,
// warn/timeout flags and an active-low LED pattern. Option: COUNTDOWN_BLINK_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter logic [7:0] INIT_SEC = 8'h30,
  parameter logic [7:0] WARN_SEC = 8'h05
) (
  input  logic       clk1h,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       clr,
  input  logic       load_en,
  input  logic [7:0] load_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       busy,
  output logic       warn,
  output logic       timeout,
  output logic [7:0] led
);

  state_t     r_state;
  logic [7:0] r_preset;
  logic [7:0] r_count;
  logic       r_timeout;
  logic [7:0] r_led;

  logic [7:0] w_dec_in;
  logic [7:0] w_dec;
  logic       w_dec_valid;

  // In IDLE the decrementer only serves as the load-value validity check.
  assign w_dec_in = (r_state == IDLE) ? load_bcd : r_count;

  bcd_dec2 u_dec (
    .i_bcd   (w_dec_in),
    .o_dec   (w_dec),
    .o_valid (w_dec_valid)
  );

  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_preset  <= INIT_SEC;
      r_count   <= INIT_SEC;
      r_timeout <= 1'b0;
      r_led     <= LED_OFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_timeout <= 1'b0;
      if (clr) begin
        r_state <= IDLE;
        r_count <= r_preset;
        r_led   <= LED_OFF;
      end else if (start) begin
        r_count <= r_preset;
        if (r_preset == BCD_ZERO) begin
          r_state   <= DONE;
          r_timeout <= 1'b1;
          r_led     <= LED_ON;
        end else begin
          r_state <= RUN;
          r_led   <= LED_FIRST;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (load_en && w_dec_valid) begin
              r_preset <= load_bcd;
              r_count  <= load_bcd;
            end else begin
              r_count <= r_preset;
            end
          end
          RUN: begin
            if (hold) begin
              r_state <= PAUSE;
            end else begin
              r_count <= w_dec;
              if (w_dec == BCD_ZERO) begin
                r_state   <= DONE;
                r_timeout <= 1'b1;
                r_led     <= LED_ON;
              end else begin
                r_led <= {r_led[0], r_led[7:1]};
              end
            end
          end
          PAUSE: begin
            if (!hold) r_state <= RUN;
          end
          DONE: begin
`ifdef COUNTDOWN_BLINK_EN
            r_led <= ~r_led;
`else
            r_led <= LED_ON;
`endif
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sec_tens = r_count[7:4];
  assign sec_ones = r_count[3:0];
  assign busy     = (r_state == RUN) || (r_state == PAUSE);
  assign warn     = busy && (r_count <= WARN_SEC);
  assign timeout  = r_timeout;
  assign led      = r_led;

endmodule
